pipe_in_last_arbiter: RTL and testbench
=======================================

PIPE_IN_LAST_ARBITER -- requirements
Module: pipe_in_last_arbiter

Interface
REQ-001 SHALL have parameter width, default 32, data word width per beat.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of PipeInLast sources (legal 2..8).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_enq__ENA  input  NUM_REQ  per-source beat enable; bit i belongs to source i.
REQ-006 SHALL have port in_enq__RDY  output  NUM_REQ  per-source ready.
REQ-007 SHALL have port in_enq$v  input  NUM_REQ*width  per-source data; source i in bits [i*width +: width].
REQ-008 SHALL have port in_enq$last  input  NUM_REQ  per-source last-beat-of-message flag.
REQ-009 SHALL have port out_enq__ENA  output  1  merged beat enable.
REQ-010 SHALL have port out_enq__RDY  input  1  downstream ready.
REQ-011 SHALL have port out_enq$v  output  width  merged data.
REQ-012 SHALL have port out_enq$last  output  1  merged last flag.
REQ-013 SHALL have port grant  output  NUM_REQ  one-hot source currently offered RDY; zero when out_enq__RDY low.
REQ-014 SHALL have port locked  output  1  high while a multi-beat message is in progress.
REQ-015 SHALL have port msg_count  output  16  completed messages forwarded, wraps 0xFFFF->0.
REQ-016 SHALL have port protocol_err  output  1  sticky: some in_enq__ENA bit asserted without its RDY.

Function
REQ-017 SHALL implement states IDLE and LOCKED, plus registers ptr (log2 NUM_REQ bits, candidate/owner index), msg_count, protocol_err.
REQ-018 SHALL, in both states, drive in_enq__RDY[i] = out_enq__RDY & (i == ptr); all other RDY bits 0; grant equals in_enq__RDY.
REQ-019 SHALL forward combinationally (zero latency): out_enq__ENA = in_enq__ENA[ptr] & in_enq__RDY[ptr]; out_enq$v, out_enq$last = source ptr's fields when out_enq__ENA, else 0.
REQ-020 SHALL define a beat as out_enq__ENA high at a posedge.
REQ-021 IDLE, beat with last=0: go LOCKED, ptr unchanged.
REQ-022 IDLE, beat with last=1 (single-beat message): stay IDLE, msg_count+1, ptr advances.
REQ-023 IDLE, no beat and out_enq__RDY high: ptr advances (rotating offer, each source offered at least once per NUM_REQ ready cycles).
REQ-024 IDLE or LOCKED, out_enq__RDY low: ptr, state hold.
REQ-025 LOCKED, beat with last=0: stay LOCKED, ptr held; message never interleaved with another source.
REQ-026 LOCKED, beat with last=1: go IDLE, msg_count+1, ptr advances.
REQ-027 LOCKED, no beat: hold indefinitely (no timeout).
REQ-028 ptr advance SHALL be (ptr+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
REQ-029 locked SHALL be 1 exactly in state LOCKED.
REQ-030 protocol_err SHALL set on any posedge where in_enq__ENA[i] & ~in_enq__RDY[i] for some i; the offending beat is dropped (not forwarded, no state change); cleared only by reset.
REQ-031 Simultaneous enables from several sources SHALL forward only source ptr; others flag protocol_err per REQ-030.

Reset
REQ-032 SHALL, when nRST low at posedge: state IDLE, ptr 0, msg_count 0, protocol_err 0.
REQ-033 Reset mid-message SHALL abandon the lock without incrementing msg_count; outputs follow REQ-018/019 with ptr 0 from the next cycle.
REQ-034 During reset cycles all RDY outputs SHALL still follow REQ-018 (no gating beyond out_enq__RDY).

Verification
REQ-035 NUM_REQ=4, out RDY=1, source 2 holds a 3-beat message (0xA,0xB,0xC last) -> offered at cycle 2 after reset, three consecutive out beats with last on 0xC, msg_count=1, ptr=3 after.
REQ-036 All four sources send single-beat messages whenever ready -> out data sources order 0,1,2,3,0 on consecutive cycles, msg_count increments each cycle.
REQ-037 Source 1 locked mid-message, out RDY low 5 cycles -> grant=0, no beats, ptr=1, locked=1 held; resumes on RDY=1.
REQ-038 Source 3 asserts ENA while grant=0001 -> beat absent on out, protocol_err=1 and stays 1 until nRST low.
REQ-039 nRST low for one cycle after 2 of 4 beats of source 0 -> locked=0, ptr=0, msg_count unchanged, next beat from source 0 starts a new message.
REQ-040 65536 single-beat messages -> msg_count wraps to 0.

Source files
------------

// File: rtl/pipe_in_last_arbiter_if.sv
// Bus bundle for pipe_in_last_arbiter: NUM_REQ PipeInLast sources merged into one sink,
// plus status outputs. slave is the arbiter side, master is the environment side.
interface pipe_in_last_arbiter_if #(
  parameter int width   = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       in_enq__ENA;
  logic [NUM_REQ-1:0]       in_enq__RDY;
  logic [NUM_REQ*width-1:0] in_enq_v;
  logic [NUM_REQ-1:0]       in_enq_last;
  logic                     out_enq__ENA;
  logic                     out_enq__RDY;
  logic [width-1:0]         out_enq_v;
  logic                     out_enq_last;
  logic [NUM_REQ-1:0]       grant;
  logic                     locked;
  logic [15:0]              msg_count;
  logic                     protocol_err;

  modport slave (
    input  in_enq__ENA, in_enq_v, in_enq_last, out_enq__RDY,
    output in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_last,
           grant, locked, msg_count, protocol_err
  );

  modport master (
    output in_enq__ENA, in_enq_v, in_enq_last, out_enq__RDY,
    input  in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_last,
           grant, locked, msg_count, protocol_err
  );
endinterface

// File: rtl/pipe_in_last_arbiter.sv
// Round-robin merge of NUM_REQ multi-beat sources onto one zero-latency sink; a source
// keeps the sink from its first beat until its last beat so messages never interleave.
module pipe_in_last_arbiter #(
  parameter int width   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  pipe_in_last_arbiter_if.slave  io
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, ptr_inc;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q;
  logic [NUM_REQ-1:0] rdy, bad;
  logic [width-1:0]   sel_v;
  logic               sel_last, beat;

  // Only the source at ptr is offered; any other enable is a protocol violation.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign rdy[i] = io.out_enq__RDY & (ptr_q == PW'(i));
    assign bad[i] = io.in_enq__ENA[i] & ~rdy[i];
  end

  assign sel_v    = io.in_enq_v[ptr_q*width +: width];
  assign sel_last = io.in_enq_last[ptr_q];
  assign beat     = io.in_enq__ENA[ptr_q] & rdy[ptr_q];
  assign ptr_inc  = (ptr_q == PW'(NUM_REQ-1)) ? '0 : ptr_q + 1'b1;

  assign io.in_enq__RDY  = rdy;
  assign io.grant        = rdy;
  assign io.out_enq__ENA = beat;
  assign io.out_enq_v    = beat ? sel_v : '0;
  assign io.out_enq_last = beat & sel_last;
  assign io.locked       = (state_q == LOCKED);
  assign io.msg_count    = cnt_q;
  assign io.protocol_err = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (io.out_enq__RDY) begin
      case (state_q)
        IDLE: begin
          if (beat && sel_last) begin
            cnt_d = cnt_q + 16'd1;
            ptr_d = ptr_inc;
          end else if (beat) begin
            state_d = LOCKED;
          end else begin
            ptr_d = ptr_inc;
          end
        end
        LOCKED: begin
          if (beat && sel_last) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 16'd1;
            ptr_d   = ptr_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (|bad);
    end
  end
endmodule

// File: tb/tb_pipe_in_last_arbiter.sv
// Bench for pipe_in_last_arbiter (NUM_REQ=4, width=32): directed vector table, counter
// wrap sequence, and randomized traffic against a transaction-level reference model.
module tb_pipe_in_last_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  logic CLK;
  logic nRST;
  int   n_chk  = 0;
  int   n_pass = 0;

  pipe_in_last_arbiter_if #(.width(W), .NUM_REQ(N)) bus ();

  pipe_in_last_arbiter #(.width(W), .NUM_REQ(N)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .io   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [3:0]  ena;
    logic        last;
    logic [31:0] dat;
    logic [3:0]  x_grant;
    logic        x_ena;
    logic [31:0] x_v;
    logic        x_last;
    logic        x_lk;
    logic [15:0] x_cnt;
    logic        x_err;
  } vec_t;

  vec_t tbl[34];

  // Packed observation: {in RDY, grant, out ENA, out v, out last, locked, msg_count, err}
  function automatic logic [59:0] observe();
    return {bus.in_enq__RDY, bus.grant, bus.out_enq__ENA, bus.out_enq_v,
            bus.out_enq_last, bus.locked, bus.msg_count, bus.protocol_err};
  endfunction

  task automatic check(input string nm, input logic [59:0] act, input logic [59:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic rst_n, input logic rdy, input logic [3:0] ena,
                       input logic [3:0] last, input logic [N*W-1:0] v);
    nRST             = rst_n;
    bus.out_enq__RDY = rdy;
    bus.in_enq__ENA  = ena;
    bus.in_enq_last  = last;
    bus.in_enq_v     = v;
  endtask

  // Directed vectors: source i data is dat | (i << 24).
  function automatic logic [N*W-1:0] spread(input logic [31:0] dat);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = dat | (32'(i) << 24);
    return v;
  endfunction

  // Reference model state: owner/candidate index, message-in-progress, counts, sticky error.
  int        m_ptr;
  bit        m_lk;
  int        m_cnt;
  bit        m_err;
  logic [31:0] sdat[N];

  initial begin
    logic [3:0]      ena, last, g;
    logic            rdy, rst_n, ob;
    logic [N*W-1:0]  v;
    logic [59:0]     exp;
    bit              wrap_ok;

    tbl[0]  = '{0,1,4'h0,0,32'h0,   4'h1,0,32'h0,0,0,16'd0,0};
    tbl[1]  = '{1,1,4'h0,0,32'h0,   4'h1,0,32'h0,0,0,16'd0,0};
    tbl[2]  = '{1,1,4'h0,0,32'h0,   4'h2,0,32'h0,0,0,16'd0,0};
    tbl[3]  = '{1,1,4'h4,0,32'hA,   4'h4,1,32'h0200000A,0,0,16'd0,0};
    tbl[4]  = '{1,1,4'h4,0,32'hB,   4'h4,1,32'h0200000B,0,1,16'd0,0};
    tbl[5]  = '{1,1,4'h4,1,32'hC,   4'h4,1,32'h0200000C,1,1,16'd0,0};
    tbl[6]  = '{1,1,4'h0,0,32'h0,   4'h8,0,32'h0,0,0,16'd1,0};
    tbl[7]  = '{1,1,4'h1,1,32'h10,  4'h1,1,32'h00000010,1,0,16'd1,0};
    tbl[8]  = '{1,1,4'h2,1,32'h11,  4'h2,1,32'h01000011,1,0,16'd2,0};
    tbl[9]  = '{1,1,4'h4,1,32'h12,  4'h4,1,32'h02000012,1,0,16'd3,0};
    tbl[10] = '{1,1,4'h8,1,32'h13,  4'h8,1,32'h03000013,1,0,16'd4,0};
    tbl[11] = '{1,1,4'h1,1,32'h14,  4'h1,1,32'h00000014,1,0,16'd5,0};
    tbl[12] = '{1,1,4'h2,0,32'h20,  4'h2,1,32'h01000020,0,0,16'd6,0};
    for (int i = 13; i <= 17; i++)
      tbl[i] = '{1,0,4'h0,0,32'h0,  4'h0,0,32'h0,0,1,16'd6,0};
    tbl[18] = '{1,1,4'h2,1,32'h21,  4'h2,1,32'h01000021,1,1,16'd6,0};
    tbl[19] = '{1,1,4'h0,0,32'h0,   4'h4,0,32'h0,0,0,16'd7,0};
    tbl[20] = '{1,1,4'h0,0,32'h0,   4'h8,0,32'h0,0,0,16'd7,0};
    tbl[21] = '{1,1,4'h8,1,32'h99,  4'h1,0,32'h0,0,0,16'd7,0};
    tbl[22] = '{1,1,4'h0,0,32'h0,   4'h2,0,32'h0,0,0,16'd7,1};
    tbl[23] = '{1,0,4'h0,0,32'h0,   4'h0,0,32'h0,0,0,16'd7,1};
    tbl[24] = '{1,1,4'h0,0,32'h0,   4'h4,0,32'h0,0,0,16'd7,1};
    tbl[25] = '{1,1,4'h0,0,32'h0,   4'h8,0,32'h0,0,0,16'd7,1};
    tbl[26] = '{1,1,4'h1,0,32'h30,  4'h1,1,32'h00000030,0,0,16'd7,1};
    tbl[27] = '{1,1,4'h1,0,32'h31,  4'h1,1,32'h00000031,0,1,16'd7,1};
    tbl[28] = '{0,0,4'h0,0,32'h0,   4'h0,0,32'h0,0,1,16'd7,1};
    tbl[29] = '{1,1,4'h1,0,32'h40,  4'h1,1,32'h00000040,0,0,16'd0,0};
    tbl[30] = '{1,1,4'h1,0,32'h41,  4'h1,1,32'h00000041,0,1,16'd0,0};
    tbl[31] = '{0,1,4'h0,0,32'h0,   4'h1,0,32'h0,0,1,16'd0,0};
    tbl[32] = '{1,1,4'h1,1,32'h42,  4'h1,1,32'h00000042,1,0,16'd0,0};
    tbl[33] = '{1,0,4'h0,0,32'h0,   4'h0,0,32'h0,0,0,16'd1,0};

    drive(0, 0, 4'h0, 4'h0, '0);
    repeat (2) @(negedge CLK);

    for (int r = 0; r < 34; r++) begin
      drive(tbl[r].rst_n, tbl[r].rdy, tbl[r].ena, {4{tbl[r].last}}, spread(tbl[r].dat));
      #1;
      check($sformatf("vec%0d", r), observe(),
            {tbl[r].x_grant, tbl[r].x_grant, tbl[r].x_ena, tbl[r].x_v, tbl[r].x_last,
             tbl[r].x_lk, tbl[r].x_cnt, tbl[r].x_err});
      @(negedge CLK);
    end

    // msg_count wrap: 65536 single-beat messages, one per cycle in source order.
    drive(0, 0, 4'h0, 4'h0, '0);
    repeat (2) @(negedge CLK);
    wrap_ok = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      drive(1, 1, 4'(1 << (n % 4)), 4'hF, spread(32'(n)));
      #1;
      if (bus.out_enq__ENA !== 1'b1) wrap_ok = 1'b0;
      if (n == 65535) check("cnt_ffff", 60'(bus.msg_count), 60'h0FFFF);
      @(negedge CLK);
    end
    check("wrap_beats", 60'(wrap_ok), 60'd1);
    drive(1, 0, 4'h0, 4'h0, '0);
    #1;
    check("cnt_wrap0", 60'(bus.msg_count), 60'h0);
    @(negedge CLK);

    // Randomized traffic vs. model.
    drive(0, 0, 4'h0, 4'h0, '0);
    @(negedge CLK);
    m_ptr = 0; m_lk = 0; m_cnt = 0; m_err = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom % 300) != 0;
      rdy   = ($urandom % 4) != 0;
      ena   = '0;
      if (rdy && ($urandom % 3) != 0) ena[m_ptr] = 1'b1;
      if (($urandom % 64) == 0) ena[$urandom % 4] = 1'b1;
      for (int i = 0; i < N; i++) begin
        last[i] = ($urandom % 3) == 0;
        sdat[i] = $urandom;
        v[i*W +: W] = sdat[i];
      end
      drive(rst_n, rdy, ena, last, v);
      g   = rdy ? 4'(1 << m_ptr) : 4'h0;
      ob  = rdy && ena[m_ptr];
      exp = {g, g, ob, ob ? sdat[m_ptr] : 32'h0, ob && last[m_ptr], m_lk, 16'(m_cnt), m_err};
      #1;
      check($sformatf("rnd%0d", c), observe(), exp);
      if ((ena & ~g) != 4'h0) m_err = 1;
      if (!rst_n) begin
        m_ptr = 0; m_lk = 0; m_cnt = 0; m_err = 0;
      end else if (rdy) begin
        if (ob && last[m_ptr]) begin
          m_lk = 0; m_cnt = (m_cnt + 1) % 65536; m_ptr = (m_ptr + 1) % N;
        end else if (ob) begin
          m_lk = 1;
        end else if (!m_lk) begin
          m_ptr = (m_ptr + 1) % N;
        end
      end
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
